// File: rtl/plic_gen.sv
// Platform-level interrupt controller: N gated sources with priority, enable and
// edge/level mode, a global threshold, and claim/complete over a single-cycle slave port.
module plic_gen #(
    parameter int NSRC        = 8,
    parameter int PRIO_W      = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NSRC-1:0]   src,
    input  logic              req,
    input  logic              we,
    input  logic [7:0]        addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              ack,
    output logic              irq_ext
);

    localparam logic [31:0] SRC_MASK = 32'(((64'd1 << NSRC) - 64'd1) << 1);

    localparam logic [5:0] W_PEND  = 6'h20;
    localparam logic [5:0] W_EN    = 6'h21;
    localparam logic [5:0] W_MODE  = 6'h22;
    localparam logic [5:0] W_THR   = 6'h23;
    localparam logic [5:0] W_CLAIM = 6'h24;

    logic [NSRC-1:0]   src_s;
    logic [NSRC-1:0]   src_d;
    logic [31:0]       src_v, edg_v;
    logic [31:0]       pend, en, mode, insvc;
    logic [PRIO_W-1:0] thr;
    logic [PRIO_W-1:0] prio [1:NSRC];

    logic [31:0]       cand;
    logic [4:0]        win;
    logic [PRIO_W-1:0] best;
    logic [31:0]       rd_val;
    logic [31:0]       claim_vec, cmp_vec, lvl_set, edge_set;
    logic [5:0]        word;
    logic              req_ok, wr, rd;
    logic              unused_addr;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign src_s = src;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0][NSRC-1:0] sync_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= src;
                    for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
                end
            end
            assign src_s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    assign unused_addr = ^addr[1:0];
    assign word   = addr[7:2];
    // A request overlapping a pending ack is dropped.
    assign req_ok = req & ~ack;
    assign wr     = req_ok & we;
    assign rd     = req_ok & ~we;

    assign src_v    = 32'({src_s, 1'b0});
    assign edg_v    = 32'({src_s & ~src_d, 1'b0});
    assign lvl_set  = src_v & ~mode & ~insvc;
    assign edge_set = edg_v & mode;

    // Strict '>' while scanning upward keeps the lowest ID on equal priority.
    always_comb begin
        cand = '0;
        win  = '0;
        best = '0;
        for (int i = 1; i <= NSRC; i++) begin
            cand[i] = pend[i] & en[i] & (prio[i] > thr);
            if (cand[i] && (prio[i] > best)) begin
                win  = 5'(i);
                best = prio[i];
            end
        end
    end

    assign claim_vec = (rd && word == W_CLAIM) ? ((32'd1 << win) & SRC_MASK) : '0;
    assign cmp_vec   = (wr && word == W_CLAIM) ? ((32'd1 << wdata[4:0]) & insvc & en) : '0;

    always_comb begin
        rd_val = '0;
        case (word)
            W_PEND:  rd_val = pend;
            W_EN:    rd_val = en;
            W_MODE:  rd_val = mode;
            W_THR:   rd_val = 32'(thr);
            W_CLAIM: rd_val = 32'(win);
            default: begin
                for (int i = 1; i <= NSRC; i++)
                    if (word == 6'(i)) rd_val = 32'(prio[i]);
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_d   <= '0;
            ack     <= 1'b0;
            rdata   <= '0;
            irq_ext <= 1'b0;
            pend    <= '0;
            insvc   <= '0;
            en      <= '0;
            mode    <= '0;
            thr     <= '0;
            for (int i = 1; i <= NSRC; i++) prio[i] <= '0;
        end else begin
            src_d   <= src_s;
            ack     <= req_ok;
            rdata   <= rd ? rd_val : '0;
            irq_ext <= |cand;
            // A fresh edge outranks a same-cycle claim of that ID.
            pend    <= (((pend | lvl_set) & ~claim_vec) | edge_set) & SRC_MASK;
            insvc   <= (insvc & ~cmp_vec) | claim_vec;
            if (wr) begin
                case (word)
                    W_EN:   en   <= wdata & SRC_MASK;
                    W_MODE: mode <= wdata & SRC_MASK;
                    W_THR:  thr  <= wdata[PRIO_W-1:0];
                    default: begin
                        for (int i = 1; i <= NSRC; i++)
                            if (word == 6'(i)) prio[i] <= wdata[PRIO_W-1:0];
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_plic_gen.sv
// Directed bench for plic_gen with default parameters (8 sources, 3-bit priority, 2 sync stages).
module tb_plic_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  src = '0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [7:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        ack;
    logic        irq_ext;

    int checks = 0;
    int errors = 0;

    plic_gen #(.NSRC(8), .PRIO_W(3), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .src(src), .req(req), .we(we), .addr(addr),
        .wdata(wdata), .rdata(rdata), .ack(ack), .irq_ext(irq_ext)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        req = 1'b0; we = 1'b0;
        check("wr_ack", 32'(ack), 32'd1);
    endtask

    task automatic rd(input string tag, input logic [7:0] a, input logic [31:0] exp);
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = a;
        @(negedge clk);
        req = 1'b0;
        check("rd_ack", 32'(ack), 32'd1);
        check(tag, rdata, exp);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_irq", 32'(irq_ext), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        for (int a = 0; a < 160; a += 4) rd("rst_read", 8'(a), 32'd0);

        wr(8'h04, 32'hFFFF_FFFF);
        rd("prio1_trunc", 8'h04, 32'd7);
        wr(8'h04, 32'd0);
        wr(8'h00, 32'hFFFF_FFFF);
        rd("off0_ignored", 8'h00, 32'd0);
        wr(8'h80, 32'hFFFF_FFFF);
        rd("pend_ro", 8'h80, 32'd0);
        wr(8'h84, 32'hFFFF_FFFF);
        rd("en_mask", 8'h84, 32'h0000_01FE);

        // Level source 3, priority 5
        wr(8'h0C, 32'd5);
        wr(8'h84, 32'h08);
        wr(8'h88, 32'd0);
        wr(8'h8C, 32'd0);
        src[2] = 1'b1;
        repeat (3) @(negedge clk);
        check("lvl_irq_early", 32'(irq_ext), 32'd0);
        @(negedge clk);
        check("lvl_irq_4cyc", 32'(irq_ext), 32'd1);
        rd("claim_3", 8'h90, 32'd3);
        @(negedge clk);
        check("irq_fall_claim", 32'(irq_ext), 32'd0);
        wr(8'h90, 32'd3);
        repeat (2) @(negedge clk);
        check("irq_repend_level", 32'(irq_ext), 32'd1);
        src[2] = 1'b0;
        repeat (4) @(negedge clk);
        rd("claim_3_again", 8'h90, 32'd3);
        wr(8'h90, 32'd3);
        rd("pend_clean_a", 8'h80, 32'd0);

        // Sources 2,5 at prio 4 and 7 at prio 6
        wr(8'h08, 32'd4);
        wr(8'h14, 32'd4);
        wr(8'h1C, 32'd6);
        wr(8'h84, 32'hA4);
        src = 8'h52;
        repeat (5) @(negedge clk);
        src = 8'h00;
        rd("pend_multi", 8'h80, 32'hA4);
        check("irq_multi", 32'(irq_ext), 32'd1);
        wr(8'h8C, 32'd6);
        @(negedge clk);
        check("irq_thr6", 32'(irq_ext), 32'd0);
        rd("claim_thr6", 8'h90, 32'd0);
        rd("pend_after_null", 8'h80, 32'hA4);
        wr(8'h8C, 32'd0);
        rd("claim_7", 8'h90, 32'd7);
        rd("claim_2", 8'h90, 32'd2);
        rd("claim_5", 8'h90, 32'd5);
        rd("claim_none", 8'h90, 32'd0);
        check("irq_drained", 32'(irq_ext), 32'd0);
        wr(8'h90, 32'd7);
        wr(8'h90, 32'd2);
        wr(8'h90, 32'd5);
        rd("pend_clean_b", 8'h80, 32'd0);

        // Edge mode on source 4
        wr(8'h10, 32'd3);
        wr(8'h88, 32'h10);
        wr(8'h84, 32'h10);
        rd("mode_rb", 8'h88, 32'h10);
        src[3] = 1'b1;
        @(negedge clk);
        src[3] = 1'b0;
        repeat (5) @(negedge clk);
        rd("edge_pend", 8'h80, 32'h10);
        check("edge_irq", 32'(irq_ext), 32'd1);
        rd("claim_4", 8'h90, 32'd4);
        src[3] = 1'b1;
        @(negedge clk);
        src[3] = 1'b0;
        repeat (5) @(negedge clk);
        rd("edge_repend_insvc", 8'h80, 32'h10);
        src[3] = 1'b1;
        @(negedge clk);
        src[3] = 1'b0;
        rd("claim_4_edge", 8'h90, 32'd4);
        rd("edge_wins_claim", 8'h80, 32'h10);
        rd("claim_4_last", 8'h90, 32'd4);
        rd("pend_clean_c", 8'h80, 32'd0);

        // Bad completes while 4 is in service, source now level-high
        wr(8'h88, 32'd0);
        src[3] = 1'b1;
        wr(8'h90, 32'd6);
        repeat (5) @(negedge clk);
        rd("wrong_id_blocked", 8'h80, 32'd0);
        check("wrong_id_irq", 32'(irq_ext), 32'd0);
        wr(8'h90, 32'd0);
        wr(8'h90, 32'd31);
        rd("id0_31_ignored", 8'h80, 32'd0);
        wr(8'h90, 32'd4);
        rd("complete_4_repend", 8'h80, 32'h10);

        // Reset in the middle of a claim
        @(negedge clk);
        src = 8'h00;
        req = 1'b1; we = 1'b0; addr = 8'h90; rst = 1'b1;
        @(negedge clk);
        check("rst_mid_ack", 32'(ack), 32'd0);
        check("rst_mid_irq", 32'(irq_ext), 32'd0);
        check("rst_mid_rdata", rdata, 32'd0);
        req = 1'b0; rst = 1'b0;
        @(negedge clk);
        check("rst_no_late_ack", 32'(ack), 32'd0);
        rd("rst_pend", 8'h80, 32'd0);
        rd("rst_en", 8'h84, 32'd0);
        rd("rst_mode", 8'h88, 32'd0);
        rd("rst_thr", 8'h8C, 32'd0);
        rd("rst_prio4", 8'h10, 32'd0);
        rd("rst_claim", 8'h90, 32'd0);
        check("rst_end_irq", 32'(irq_ext), 32'd0);
        @(negedge clk);
        check("idle_ack", 32'(ack), 32'd0);
        check("idle_rdata", rdata, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
